// File: rtl/loop_trace_pkg.sv
// Shared types and helpers for the loop trace recorder: FSM states, the
// per-invocation record layout and a width-parameterised saturating increment.
package loop_trace_pkg;

  // Counters are carried internally at this width; instances may use any CNT_W up to it.
  localparam int unsigned CNT_W_MAX = 64;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic truncated;
    cnt_t stall_cycles;
    cnt_t iters_ended;
    cnt_t iters_started;
    cnt_t cycles;
  } trace_rec_t;

  // Adds inc to v unless v already sits at the all-ones value of a w-bit counter.
  function automatic cnt_t sat_inc(input cnt_t v, input logic inc, input int unsigned w);
    cnt_t max_v;
    max_v = {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - w);
    return (inc && (v != max_v)) ? v + cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/loop_trace_fifo.sv
// Synchronous FIFO holding finished trace records; a push into a full FIFO is
// accepted when a pop happens in the same cycle, so full-rate streaming works.
module loop_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/loop_trace_recorder.sv
// Per-invocation profiler for a pipelined HLS loop: counts cycles, issued and
// retired iterations and stall cycles, then queues one record per invocation.
module loop_trace_recorder
  import loop_trace_pkg::*;
#(
  parameter int unsigned STATE_W = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               loop_start,
  input  logic               loop_done,
  input  logic               loop_continue,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [4*CNT_W:0]   rec_data,
  output logic [CNT_W-1:0]   drop_count,
  output logic               busy
);

  localparam int unsigned REC_W = 4 * CNT_W + 1;

  // rec_data is offered with rec_valid; a record is consumed in every cycle where
  // rec_valid and rec_ready are both high, and holds steady otherwise.
  state_e         state_q, state_d;
  trace_rec_t     cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic           start_ev, end_ev, stall_ev;
  logic           push, pop, fifo_full, fifo_empty;
  logic [REC_W-1:0] push_data;

  assign start_ev = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
  assign end_ev   = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
  assign stall_ev = (cur_state == iter_start_state) && (iter_start_enable || iter_end_enable)
                    && iter_start_block;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (loop_start) begin
          state_d             = ST_RUN;
          cnt_d.truncated     = 1'b0;
          cnt_d.cycles        = cnt_t'(1);
          cnt_d.iters_started = cnt_t'(start_ev);
          cnt_d.iters_ended   = cnt_t'(end_ev);
          cnt_d.stall_cycles  = cnt_t'(stall_ev);
        end
      end
      ST_RUN: begin
        cnt_d.cycles        = sat_inc(cnt_q.cycles, 1'b1, CNT_W);
        cnt_d.iters_started = sat_inc(cnt_q.iters_started, start_ev, CNT_W);
        cnt_d.iters_ended   = sat_inc(cnt_q.iters_ended, end_ev, CNT_W);
        cnt_d.stall_cycles  = sat_inc(cnt_q.stall_cycles, stall_ev, CNT_W);
        // finish wins over a done in the same cycle and marks the record cut short.
        if (finish) begin
          cnt_d.truncated = 1'b1;
          push            = 1'b1;
          state_d         = ST_IDLE;
        end else if (loop_done) begin
          if (loop_continue) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (finish) begin
          cnt_d.truncated = 1'b1;
          push            = 1'b1;
          state_d         = ST_IDLE;
        end else if (loop_continue) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_data = {cnt_d.truncated,
                      CNT_W'(cnt_d.stall_cycles),
                      CNT_W'(cnt_d.iters_ended),
                      CNT_W'(cnt_d.iters_started),
                      CNT_W'(cnt_d.cycles)};

  assign pop    = rec_valid && rec_ready;
  // A push into a full FIFO is lost only when no pop frees a slot this cycle.
  assign drop_d = CNT_W'(sat_inc(cnt_t'(drop_q), push && fifo_full && !pop, CNT_W));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  loop_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (rec_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid  = !fifo_empty;
  assign drop_count = drop_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_loop_trace_recorder.sv
// Bench for loop_trace_recorder: directed loop scenarios plus random control
// traffic, checked every cycle against a queue-based invocation model.
module tb_loop_trace_recorder;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 8;
  localparam int REC_W   = 4 * CNT_W + 1;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic               clock, reset, finish;
  logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state;
  logic               iter_start_enable, iter_end_enable, iter_start_block, iter_end_block;
  logic               loop_start, loop_done, loop_continue;
  logic               rec_valid, rec_ready, busy;
  logic [REC_W-1:0]   rec_data;
  logic [CNT_W-1:0]   drop_count;

  int total = 0;
  int bad   = 0;

  // Model: one open invocation plus the queue of records the consumer should see.
  logic [REC_W-1:0] exp_q[$];
  bit m_open, m_hold;
  int m_cyc, m_st, m_en, m_sl, m_drop;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  loop_trace_recorder #(
    .STATE_W (STATE_W),
    .CNT_W   (CNT_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .finish            (finish),
    .cur_state         (cur_state),
    .iter_start_state  (iter_start_state),
    .iter_end_state    (iter_end_state),
    .iter_start_enable (iter_start_enable),
    .iter_end_enable   (iter_end_enable),
    .iter_start_block  (iter_start_block),
    .iter_end_block    (iter_end_block),
    .loop_start        (loop_start),
    .loop_done         (loop_done),
    .loop_continue     (loop_continue),
    .rec_valid         (rec_valid),
    .rec_ready         (rec_ready),
    .rec_data          (rec_data),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  // ---------------- model helpers ----------------
  function automatic int sat(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  function automatic logic [REC_W-1:0] mk(input bit t, input int sl, input int en,
                                          input int st, input int cyc);
    return {t, CNT_W'(sl), CNT_W'(en), CNT_W'(st), CNT_W'(cyc)};
  endfunction

  task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit s_ev, e_ev, l_ev, do_pop, do_push, trunc;
    if (reset) begin
      m_open = 0; m_hold = 0; m_drop = 0;
      exp_q.delete();
      return;
    end
    s_ev = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    e_ev = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    l_ev = (cur_state == iter_start_state) && (iter_start_enable || iter_end_enable)
           && iter_start_block;
    do_pop  = (exp_q.size() > 0) && rec_ready;
    do_push = 0;
    trunc   = 0;
    if (!m_open) begin
      if (loop_start) begin
        m_open = 1; m_hold = 0;
        m_cyc = 1; m_st = int'(s_ev); m_en = int'(e_ev); m_sl = int'(l_ev);
      end
    end else if (!m_hold) begin
      m_cyc = sat(m_cyc);
      if (s_ev) m_st = sat(m_st);
      if (e_ev) m_en = sat(m_en);
      if (l_ev) m_sl = sat(m_sl);
      if (finish) begin do_push = 1; trunc = 1; end
      else if (loop_done) begin
        if (loop_continue) do_push = 1;
        else m_hold = 1;
      end
    end else begin
      if (finish) begin do_push = 1; trunc = 1; end
      else if (loop_continue) do_push = 1;
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      m_open = 0; m_hold = 0;
      if (exp_q.size() < DEPTH) exp_q.push_back(mk(trunc, m_sl, m_en, m_st, m_cyc));
      else m_drop = sat(m_drop);
    end
  endtask

  // One clock: update the model from the driven inputs, then compare all outputs.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check("rec_valid", REC_W'(rec_valid), REC_W'(exp_q.size() != 0));
    check("rec_data", rec_data, (exp_q.size() != 0) ? exp_q[0] : '0);
    check("drop_count", REC_W'(drop_count), REC_W'(m_drop));
    check("busy", REC_W'(busy), REC_W'(m_open));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reset = 0; finish = 0;
    cur_state = 2'd0; iter_start_state = 2'd1; iter_end_state = 2'd1;
    iter_start_enable = 0; iter_end_enable = 0;
    iter_start_block = 0; iter_end_block = 0;
    loop_start = 0; loop_done = 0; loop_continue = 0;
  endtask

  // Emulates a pipelined loop: one issue per unblocked cycle, retire lat cycles later.
  task automatic run_loop(input int iters, input int lat, input int blk_lo, input int blk_hi,
                          input int cont_delay, input int fin_at, input int rst_at);
    int end_q[$];
    int issued, retired;
    bit done_seen;
    issued = 0; retired = 0; done_seen = 0;
    cur_state = 2'd1; iter_start_state = 2'd1; iter_end_state = 2'd1;
    for (int c = 1; c <= 400; c++) begin
      loop_start        = (c == 1);
      iter_start_enable = (issued < iters);
      iter_start_block  = (c >= blk_lo) && (c <= blk_hi);
      if (iter_start_enable && !iter_start_block) begin
        issued++;
        end_q.push_back(c + lat);
      end
      iter_end_enable = 0;
      if (end_q.size() > 0 && end_q[0] == c) begin
        void'(end_q.pop_front());
        iter_end_enable = 1;
        retired++;
      end
      loop_done     = iter_end_enable && (retired == iters);
      loop_continue = loop_done && (cont_delay == 0);
      finish        = (c == fin_at);
      reset         = (c == rst_at);
      tick();
      if (finish || reset) begin
        idle_inputs();
        return;
      end
      if (loop_done) begin
        done_seen = 1;
        break;
      end
    end
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL loop_bound observed=no_done expected=done_within_400");
    end
    idle_inputs();
    cur_state = 2'd1;
    if (cont_delay > 0) begin
      for (int k = 1; k < cont_delay; k++) tick();
      loop_continue = 1;
      tick();
      loop_continue = 0;
    end
  endtask

  task automatic pop_one();
    rec_ready = 1;
    tick();
    rec_ready = 0;
  endtask

  task automatic rand_inputs(input int ready_pct);
    cur_state         = STATE_W'($urandom_range(0, 2));
    iter_start_state  = 2'd1;
    iter_end_state    = 2'd2;
    iter_start_enable = ($urandom_range(0, 99) < 70);
    iter_end_enable   = ($urandom_range(0, 99) < 60);
    iter_start_block  = ($urandom_range(0, 99) < 25);
    iter_end_block    = ($urandom_range(0, 99) < 20);
    loop_start        = ($urandom_range(0, 99) < 40);
    loop_done         = ($urandom_range(0, 99) < 15);
    loop_continue     = ($urandom_range(0, 99) < 50);
    finish            = ($urandom_range(0, 99) < 3);
    rec_ready         = ($urandom_range(0, 99) < ready_pct);
    reset             = ($urandom_range(0, 999) < 3);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    rec_ready = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    check("reset_valid", REC_W'(rec_valid), '0);
    check("reset_data", rec_data, '0);
    check("reset_busy", REC_W'(busy), '0);

    // II=1, 10 iterations, latency 5
    run_loop(10, 5, 0, -1, 0, 0, 0);
    tick();
    check("basic_rec", rec_data, mk(0, 0, 10, 10, 15));
    pop_one();

    // start stage blocked in cycles 4-6
    run_loop(10, 5, 4, 6, 0, 0, 0);
    tick();
    check("stall_rec", rec_data, mk(0, 3, 10, 10, 18));
    pop_one();

    // done without continue, continue arrives 4 cycles later
    run_loop(10, 5, 0, -1, 4, 0, 0);
    check("hold_busy_after_push", REC_W'(busy), '0);
    check("hold_rec", rec_data, mk(0, 0, 10, 10, 15));
    pop_one();

    // ten back-to-back invocations into a stalled consumer
    for (int i = 0; i < 10; i++) run_loop(i + 1, 2, 0, -1, 0, 0, 0);
    tick();
    check("overflow_drop", REC_W'(drop_count), REC_W'(2));
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_%0d", i), rec_data, mk(0, 0, i + 1, i + 1, i + 3));
      pop_one();
    end
    check("drain_empty", REC_W'(rec_valid), '0);

    // finish mid-invocation, then finish while idle
    run_loop(10, 5, 0, -1, 0, 7, 0);
    check("finish_busy", REC_W'(busy), '0);
    check("finish_rec", rec_data, mk(1, 0, 2, 7, 7));
    pop_one();
    finish = 1;
    tick();
    finish = 0;
    check("finish_idle_valid", REC_W'(rec_valid), '0);

    // reset while three records wait and a fourth invocation is open
    for (int i = 0; i < 3; i++) run_loop(2, 1, 0, -1, 0, 0, 0);
    run_loop(10, 5, 0, -1, 0, 0, 5);
    check("rst_valid", REC_W'(rec_valid), '0);
    check("rst_drop", REC_W'(drop_count), '0);
    check("rst_busy", REC_W'(busy), '0);
    tick();

    // counters clamp at the all-ones value
    run_loop(300, 1, 0, -1, 0, 0, 0);
    tick();
    check("sat_rec", rec_data, mk(0, 0, MAXV, MAXV, MAXV));
    pop_one();

    // random control traffic: slow consumer, then near full-rate consumer
    for (int n = 0; n < 1500; n++) begin
      rand_inputs(25);
      tick();
    end
    for (int n = 0; n < 1500; n++) begin
      rand_inputs(90);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loop_trace_recorder.md
# loop_trace_recorder

Synthesizable per-loop profiler that sits directly downstream of a pipelined HLS loop's control signals, the same signal set the cosim loop monitor samples: FSM state, iteration start/end enables, subdone blocks, start/done/continue. It turns each loop invocation into one summary record: total cycles, iterations issued, iterations retired, stall cycles. Records are queued in a small FIFO and drained over a valid/ready stream by the trace-dump logic. This gives the loop-status statistics on hardware runs, where no CSV dumper exists.

## Interface
Parameters:
- STATE_W, 1: width of the loop FSM state vector.
- CNT_W, 32: width of each record counter.
- DEPTH, 8: record FIFO depth; must be a power of two and at least 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high; clears all state.
- finish  in  1  end of run; flushes an open invocation as a truncated record.
- cur_state  in  STATE_W  loop FSM current state.
- iter_start_state, iter_end_state  in  STATE_W  state codes for iteration start and end.
- iter_start_enable, iter_end_enable  in  1  pipeline stage-0 and last-stage enables.
- iter_start_block, iter_end_block  in  1  subdone block for the start and end stages.
- loop_start, loop_done, loop_continue  in  1  loop handshake (ap_start, ap_done_int, ap_continue).
- rec_valid  out  1  FIFO non-empty.
- rec_ready  in  1  consumer accepts the head record.
- rec_data  out  4*CNT_W+1  {truncated, stall_cycles, iters_ended, iters_started, cycles}, with cycles in the LSBs.
- drop_count  out  CNT_W  records lost because the FIFO was full; saturates.
- busy  out  1  an invocation is open (state is not IDLE).

## Operation
- Per-cycle events, all qualified by state not being IDLE, or by the IDLE→RUN transition cycle:
  - start_ev = (cur_state==iter_start_state) & iter_start_enable & !iter_start_block
  - end_ev = (cur_state==iter_end_state) & iter_end_enable & !iter_end_block
  - stall_ev = (cur_state==iter_start_state) & (iter_start_enable | iter_end_enable) & iter_start_block
- FSM states are IDLE, RUN and HOLD.
  - IDLE → RUN when loop_start=1. That cycle loads cycles=1 and loads each of the other counters with its event bit.
  - RUN, each cycle: cycles+=1 and each counter += its event bit.
  - RUN, loop_done=1: the done cycle's increments are included. If loop_continue=1, the record is pushed this cycle and the FSM goes to IDLE; otherwise it goes to HOLD.
  - HOLD: counters are frozen. When loop_continue=1 the record is pushed and the FSM goes to IDLE.
- All counters saturate at 2^CNT_W−1 and never wrap.
- finish=1 while in RUN or HOLD:
  - The current record is pushed with truncated=1 and the FSM goes to IDLE.
  - This takes precedence over loop_done in the same cycle.
  - finish in IDLE has no effect.
- FIFO push when full:
  - Without a simultaneous pop, the record is dropped and drop_count += 1 (saturating).
  - With a simultaneous pop, the push is accepted and nothing is dropped.
- Pop on rec_valid & rec_ready.
- rec_data always presents the head entry and is stable while rec_valid=1 & rec_ready=0.
- Back-to-back invocations: if loop_start is still high in the cycle after a push, that cycle is cycle 1 of the next invocation. No cycles are lost.

## Timing
- Reset values: rec_valid=0, rec_data=0, drop_count=0, busy=0, FSM in IDLE, FIFO empty, counters 0.
- Reset mid-invocation discards the open record. Reset with records queued discards all of them.
- Push-to-visible latency is 1 cycle: a record pushed in cycle t gives rec_valid=1 in t+1 when the FIFO was empty.
- Pop is registered: the next entry, or rec_valid=0, appears in the cycle after the handshake.
- busy is registered: it is high from the cycle after the IDLE→RUN transition through the push cycle, and low the cycle after the push.
- Full-rate throughput: one push and one pop per cycle can be sustained indefinitely.

## Structure
- Package loop_trace_pkg holds:
  - the state enum {IDLE, RUN, HOLD};
  - the record struct (truncated, stall_cycles, iters_ended, iters_started, cycles);
  - a saturating-increment function, parameterised by width.
- Sub-module loop_trace_fifo: generic synchronous FIFO with DEPTH entries, push/pop/full/empty, simultaneous push-and-pop allowed when full. It is instantiated once.
- The top level holds the event decode, FSM, counters and drop counter.

## Test plan
- Single invocation, II=1, 10 iterations, end-stage latency 5:
  - Stimulus: loop_start for 1 cycle, start_ev in cycles 1-10, end_ev in cycles 6-15, done in cycle 15.
  - Required record: cycles=15, started=10, ended=10, stall=0, truncated=0.
- Stall injection: same loop with iter_start_block held high in cycles 4-6 → stall=3, cycles=18.
- HOLD path: loop_continue=0 at done, raised 4 cycles later → cycles equal the done-cycle count, and the push happens in the continue cycle.
- Overflow, DEPTH=8, rec_ready=0: 10 invocations → 8 records queued and drop_count=2. Then raise rec_ready → records drain in order with invocation 1 first.
- finish mid-invocation at cycle 7 → truncated=1, cycles=7, FSM returns to IDLE, busy falls the next cycle.
- Reset asserted at cycle 5 of an invocation, with 3 records queued → rec_valid=0, drop_count=0 and busy=0 on the next cycle. No record is emitted.
